// File: rtl/mode_sequencer.sv
// UI mode sequencer: display/edit state machine with down-button auto-repeat,
// inactivity timeout and a commit strobe when an edit state is left.
module mode_sequencer #(
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int TIMEOUT_S     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       set_btn,
  input  logic       down_btn,
  output logic [3:0] state,
  output logic       inc_n,
  output logic       editing,
  output logic       commit
);

  localparam int HW = $clog2(HOLD_DELAY + 1);
  localparam int RW = $clog2(REPEAT_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_DELAY);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] IDLE_MAX   = TW'(TIMEOUT_S);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_S - 1);

  typedef enum logic [3:0] {
    TIME_DISP        = 4'd0,  DATE_DISP        = 4'd1,
    TIME_EDIT_HOUR   = 4'd2,  TIME_EDIT_MIN    = 4'd3,
    TIME_EDIT_SEC    = 4'd4,  DATE_EDIT_DAY    = 4'd5,
    DATE_EDIT_MONTH  = 4'd6,  DATE_EDIT_YEAR   = 4'd7,
    ALARM_DISP       = 4'd8,  ALARM_EDIT_HOUR  = 4'd9,
    ALARM_EDIT_MIN   = 4'd10, ALARM_EDIT_SEC   = 4'd11,
    TIMER_DISP       = 4'd12, TIMER_EDIT_SEC   = 4'd13,
    TIMER_EDIT_MIN   = 4'd14, TIMER_EDIT_HOUR  = 4'd15
  } state_e;

  function automatic logic is_edit(input state_e s);
    case (s)
      TIME_DISP, DATE_DISP, ALARM_DISP, TIMER_DISP: is_edit = 1'b0;
      default:                                      is_edit = 1'b1;
    endcase
  endfunction

  function automatic state_e group_disp(input state_e s);
    case (s)
      ALARM_DISP, ALARM_EDIT_HOUR, ALARM_EDIT_MIN, ALARM_EDIT_SEC: group_disp = ALARM_DISP;
      TIMER_DISP, TIMER_EDIT_SEC, TIMER_EDIT_MIN, TIMER_EDIT_HOUR: group_disp = TIMER_DISP;
      default:                                                     group_disp = TIME_DISP;
    endcase
  endfunction

  function automatic state_e mode_next(input state_e s);
    case (s)
      TIME_DISP:  mode_next = DATE_DISP;
      DATE_DISP:  mode_next = ALARM_DISP;
      ALARM_DISP: mode_next = TIMER_DISP;
      TIMER_DISP: mode_next = TIME_DISP;
      default:    mode_next = group_disp(s);
    endcase
  endfunction

  function automatic state_e set_next(input state_e s);
    case (s)
      TIME_DISP, DATE_DISP: set_next = TIME_EDIT_HOUR;
      DATE_EDIT_YEAR:       set_next = TIME_DISP;
      ALARM_DISP:           set_next = ALARM_EDIT_HOUR;
      ALARM_EDIT_SEC:       set_next = ALARM_DISP;
      TIMER_DISP:           set_next = TIMER_EDIT_SEC;
      TIMER_EDIT_HOUR:      set_next = TIMER_DISP;
      default:              set_next = state_e'(s + 4'd1);
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          down_prev_q;
  logic          suppress_q, suppress_d;
  logic          inc_n_q, editing_q, commit_q;
  logic          timeout_s, press_s, repeat_s, fire_s, edit_now_s;

  assign state   = state_q;
  assign inc_n   = inc_n_q;
  assign editing = editing_q;
  assign commit  = commit_q;

  // Next state: mode beats set, and either button beats a coincident timeout.
  always_comb begin
    edit_now_s = is_edit(state_q);
    timeout_s  = edit_now_s & tick_1hz & (idle_q >= IDLE_LAST);
    state_d    = state_q;
    if (mode_btn) begin
      state_d = mode_next(state_q);
    end else if (set_btn) begin
      state_d = set_next(state_q);
    end else if (timeout_s) begin
      state_d = group_disp(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // Hold/repeat counters, increment strobe qualification and inactivity counter.
  always_comb begin
    hold_d     = hold_q;
    rep_d      = rep_q;
    suppress_d = suppress_q;
    idle_d     = idle_q;
    if (down_btn) begin
      hold_d = HW'(0);
      rep_d  = RW'(0);
    end else begin
      if (hold_q < HOLD_MAX) begin
        hold_d = hold_q + HW'(1);
      end else begin
        hold_d = hold_q;
      end
      // rep_q reloads on every strobe so the first repeat lands exactly at HOLD_DELAY.
      if (hold_q == HOLD_MAX) begin
        rep_d = (rep_q == RW'(0)) ? REP_RELOAD : rep_q - RW'(1);
      end else begin
        rep_d = rep_q;
      end
    end
    press_s  = down_prev_q & ~down_btn;
    repeat_s = ~down_btn & (hold_q == HOLD_MAX) & (rep_q == RW'(0));
    fire_s   = edit_now_s & (state_d == state_q) & ~suppress_q & (press_s | repeat_s);
    if (down_btn) begin
      suppress_d = 1'b0;
    end else if (state_d != state_q) begin
      suppress_d = 1'b1;
    end else begin
      suppress_d = suppress_q;
    end
    if (!edit_now_s || mode_btn || set_btn || !inc_n_q) begin
      idle_d = TW'(0);
    end else if (tick_1hz && (idle_q < IDLE_MAX)) begin
      idle_d = idle_q + TW'(1);
    end else begin
      idle_d = idle_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TIME_DISP;
      hold_q      <= HW'(0);
      rep_q       <= RW'(0);
      idle_q      <= TW'(0);
      down_prev_q <= 1'b1;
      suppress_q  <= 1'b0;
      inc_n_q     <= 1'b1;
      editing_q   <= 1'b0;
      commit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      idle_q      <= idle_d;
      down_prev_q <= down_btn;
      suppress_q  <= suppress_d;
      inc_n_q     <= ~fire_s;
      editing_q   <= is_edit(state_d);
      commit_q    <= is_edit(state_q) & ~is_edit(state_d);
    end
  end

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter HOLD_DELAY, default 50_000_000: clk cycles down_btn must be held before auto-repeat starts.
REQ-002 Parameter REPEAT_PERIOD, default 10_000_000: clk cycles between auto-repeat pulses.
REQ-003 Parameter TIMEOUT_S, default 10: seconds (tick_1hz pulses) of inactivity before an edit state is abandoned.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: system clock; all logic on the rising edge.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port tick_1hz, input, 1: one-cycle strobe, once per second.
REQ-008 Port mode_btn, input, 1: debounced, one-cycle active-high press pulse.
REQ-009 Port set_btn, input, 1: debounced, one-cycle active-high press pulse.
REQ-010 Port down_btn, input, 1: debounced level, active-low (0 = held).
REQ-011 Port state, output, 4: current UI state, using the shared encoding 0..15 (TIME_DISP=0 … TIMER_EDIT_HOUR=15).
REQ-012 Port inc_n, output, 1: active-low one-cycle increment strobe to the field-edit datapath.
REQ-013 Port editing, output, 1: high while state is any *_EDIT_* code (2-7, 9-11, 13-15).
REQ-014 Port commit, output, 1: one-cycle active-high pulse when an edit state is left.

Function
REQ-015 mode_btn in display states SHALL cycle TIME_DISP→DATE_DISP→ALARM_DISP→TIMER_DISP→TIME_DISP, one step per pulse.
REQ-016 set_btn SHALL step TIME_DISP or DATE_DISP→2→3→4→5→6→7→TIME_DISP; ALARM_DISP→9→10→11→ALARM_DISP; TIMER_DISP→13→14→15→TIMER_DISP.
REQ-017 mode_btn in an edit state SHALL return directly to that group's display state (2-7→0, 9-11→8, 13-15→12).
REQ-018 When mode_btn and set_btn pulse in the same cycle, mode_btn SHALL take priority and set_btn SHALL be ignored.
REQ-019 State SHALL update on the clock edge after the button pulse (1-cycle latency).
REQ-020 commit SHALL pulse in the same cycle the state register leaves an edit state for a display state, whether by set, mode or timeout; edit→edit steps SHALL NOT pulse commit.
REQ-021 In an edit state, a 1→0 transition of down_btn SHALL drive inc_n low for exactly one cycle, on the next clock edge.
REQ-022 While down_btn stays 0, a hold counter SHALL count cycles. When it reaches HOLD_DELAY, inc_n SHALL pulse, then pulse again every REPEAT_PERIOD cycles until release.
REQ-023 The hold counter SHALL saturate and not wrap; release (down_btn=1) SHALL clear it in the next cycle.
REQ-024 inc_n SHALL stay 1 in display states and in any cycle where state changes.
REQ-025 A state change while down_btn is held SHALL suppress all inc_n pulses until down_btn returns to 1.
REQ-026 In edit states, an inactivity counter SHALL increment on tick_1hz.
REQ-027 Any mode_btn, set_btn or inc_n pulse SHALL clear the inactivity counter; entering an edit state from a display state SHALL also clear it.
REQ-028 When the inactivity counter reaches TIMEOUT_S, the block SHALL go to the group display state and pulse commit.
REQ-029 A button pulse in the same cycle as the timeout SHALL win; the timeout SHALL be discarded.
REQ-030 Counter widths SHALL be $clog2(param+1) bits.

Reset
REQ-031 With rst=1 at a clock edge: state=TIME_DISP, inc_n=1, editing=0, commit=0, and all counters and edge-detect registers cleared. The edge-detect register SHALL be set to 1 (released).
REQ-032 Reset SHALL override all inputs in the same cycle, including mid-edit and mid-repeat; no commit SHALL pulse on reset.

Verification (HOLD_DELAY=4, REPEAT_PERIOD=2, TIMEOUT_S=3)
REQ-033 Reset, then 4 mode_btn pulses → state 0→1→8→12→0; commit stays 0.
REQ-034 From TIME_DISP, 7 set_btn pulses → state 2,3,4,5,6,7,0; commit=1 only on the 7→0 cycle.
REQ-035 In state 3, hold down_btn=0 for 10 cycles → inc_n low at cycles 1, 5, 7 and 9 after the press; no pulse after release.
REQ-036 In state 10, no buttons, 3 tick_1hz pulses → state=8 and commit=1 on the cycle after the third tick; a set_btn coincident with the third tick instead gives state=11.
REQ-037 In state 13, mode_btn and set_btn in the same cycle → state=12, commit=1; down_btn held across the transition → no inc_n pulses.
REQ-038 In state 5 with down_btn held, assert rst for 1 cycle → state=0, inc_n=1, commit=0; a later press in state 2 gives a single inc_n pulse.
